// File: rtl/csr_file_pkg.sv
// Shared definitions for the machine-mode CSR file: address map, operation encodings and
// mstatus layout.
package csr_file_pkg;

    localparam logic [11:0] CsrMstatus   = 12'h300;
    localparam logic [11:0] CsrMisa      = 12'h301;
    localparam logic [11:0] CsrMtvec     = 12'h305;
    localparam logic [11:0] CsrMscratch  = 12'h340;
    localparam logic [11:0] CsrMepc      = 12'h341;
    localparam logic [11:0] CsrMcause    = 12'h342;
    localparam logic [11:0] CsrMcycle    = 12'hB00;
    localparam logic [11:0] CsrMinstret  = 12'hB02;
    localparam logic [11:0] CsrMcycleh   = 12'hB80;
    localparam logic [11:0] CsrMinstreth = 12'hB82;
    localparam logic [11:0] CsrCycle     = 12'hC00;
    localparam logic [11:0] CsrInstret   = 12'hC02;
    localparam logic [11:0] CsrCycleh    = 12'hC80;
    localparam logic [11:0] CsrInstreth  = 12'hC82;
    localparam logic [11:0] CsrMhartid   = 12'hF14;

    typedef enum logic [1:0] {
        MocsrNone = 2'b00,
        MocsrRw   = 2'b01,
        MocsrRs   = 2'b10,
        MocsrRc   = 2'b11
    } mocsr_e;

    localparam int unsigned MstatusMie  = 3;
    localparam int unsigned MstatusMpie = 7;

    localparam logic [31:0] MisaValue = 32'h4000_0100;

    // MPP is hardwired to machine mode; only MIE and MPIE are stored.
    function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
        return {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter split into two 32-bit halves; a write to a half in the same cycle replaces
// that half's increment or carry.
module csr_counter64 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    input  logic        lo_we_i,
    input  logic        hi_we_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] value_o
);

    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic        carry;

    // A written low half does not increment, so it cannot carry either.
    assign carry = inc_i && !lo_we_i && (lo_q == 32'hFFFF_FFFF);

    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        if (lo_we_i) begin
            lo_d = wdata_i;
        end else if (inc_i) begin
            lo_d = lo_q + 32'd1;
        end
        if (hi_we_i) begin
            hi_d = wdata_i;
        end else if (carry) begin
            hi_d = hi_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign value_o = {hi_q, lo_q};

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: executes CSRRW/RS/RC, keeps cycle/instret counters and records trap
// state; the old CSR value is returned combinationally for writeback.
module csr_file
    import csr_file_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_w,
    input  logic        csr_inm,
    input  logic [1:0]  mocsr,
    input  logic [11:0] csr_addr,
    input  logic [4:0]  rs1_idx,
    input  logic [31:0] rs1_data,
    input  logic        retire,
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic        mret,
    output logic [31:0] csr_rdata,
    output logic        illegal,
    output logic [31:0] mepc_o,
    output logic [31:0] mtvec_o,
    output logic        mie_o
);

    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [63:0] cycle_val, instret_val;

    mocsr_e      op;
    logic [31:0] operand, wdata;
    logic        mapped, we_cand, we;

    assign op      = mocsr_e'(mocsr);
    assign operand = csr_inm ? {27'b0, rs1_idx} : rs1_data;

    always_comb begin
        csr_rdata = '0;
        mapped    = 1'b1;
        case (csr_addr)
            CsrMstatus:                 csr_rdata = mstatus_pack(mie_q, mpie_q);
            CsrMisa:                    csr_rdata = MisaValue;
            CsrMtvec:                   csr_rdata = mtvec_q;
            CsrMscratch:                csr_rdata = mscratch_q;
            CsrMepc:                    csr_rdata = mepc_q;
            CsrMcause:                  csr_rdata = mcause_q;
            CsrMcycle, CsrCycle:        csr_rdata = cycle_val[31:0];
            CsrMcycleh, CsrCycleh:      csr_rdata = cycle_val[63:32];
            CsrMinstret, CsrInstret:    csr_rdata = instret_val[31:0];
            CsrMinstreth, CsrInstreth:  csr_rdata = instret_val[63:32];
            CsrMhartid:                 csr_rdata = HART_ID;
            default:                    mapped    = 1'b0;
        endcase
    end

    // RS/RC with a zero source never write, so they may read read-only CSRs legally.
    assign we_cand = csr_w && (op != MocsrNone) && !(mocsr[1] && (rs1_idx == 5'd0));
    assign illegal = !mapped || ((csr_addr[11:10] == 2'b11) && we_cand);
    assign we      = we_cand && !illegal && !trap_valid;

    always_comb begin
        wdata = operand;
        case (op)
            MocsrRw: wdata = operand;
            MocsrRs: wdata = csr_rdata | operand;
            MocsrRc: wdata = csr_rdata & ~operand;
            default: wdata = operand;
        endcase
    end

    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        if (we && csr_addr == CsrMtvec)    mtvec_d    = wdata & 32'hFFFF_FFFC;
        if (we && csr_addr == CsrMscratch) mscratch_d = wdata;
        if (we && csr_addr == CsrMepc)     mepc_d     = wdata & 32'hFFFF_FFFC;
        if (we && csr_addr == CsrMcause)   mcause_d   = wdata;
        if (trap_valid) begin
            mepc_d   = trap_pc & 32'hFFFF_FFFC;
            mcause_d = trap_cause;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (we && csr_addr == CsrMstatus) begin
            mie_d  = wdata[MstatusMie];
            mpie_d = wdata[MstatusMpie];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

    csr_counter64 u_cycle (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (1'b1),
        .lo_we_i (we && (csr_addr == CsrMcycle)),
        .hi_we_i (we && (csr_addr == CsrMcycleh)),
        .wdata_i (wdata),
        .value_o (cycle_val)
    );

    csr_counter64 u_instret (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (retire),
        .lo_we_i (we && (csr_addr == CsrMinstret)),
        .hi_we_i (we && (csr_addr == CsrMinstreth)),
        .wdata_i (wdata),
        .value_o (instret_val)
    );

    assign mepc_o  = mepc_q;
    assign mtvec_o = mtvec_q;
    assign mie_o   = mie_q;

endmodule
